// File: rtl/kfpcjr_bus_pkg.sv
// rtl/kfpcjr_bus_pkg.sv - shared 8088 bus types and strobe decode
package kfpcjr_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } ready_gen_state_t;

  // Any active-low bus strobe asserted means a bus cycle is in progress.
  function automatic logic bus_strobe_active(
    input logic ior_n,
    input logic iow_n,
    input logic memr_n,
    input logic memw_n
  );
    return ~ior_n | ~iow_n | ~memr_n | ~memw_n;
  endfunction

endpackage

// File: rtl/ext_ready_generator.sv
// rtl/ext_ready_generator.sv - peripheral-side wait-state generator driving EXT_READY
module ext_ready_generator
  import kfpcjr_bus_pkg::*;
#(
  parameter int WAIT_WIDTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_clock_posedge,
  input  logic                  cpu_clock_negedge,
  input  logic                  IOR_N,
  input  logic                  IOW_N,
  input  logic                  MEMR_N,
  input  logic                  MEMW_N,
  input  logic                  device_select,
  input  logic [WAIT_WIDTH-1:0] wait_count,
  input  logic                  use_ack,
  input  logic                  device_ack,
  output logic                  EXT_READY,
  output logic                  timeout_pulse,
  output logic                  busy
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

  ready_gen_state_t state, next_state;

  logic [WAIT_WIDTH-1:0] cnt, cnt_d;
  logic [TMO_W-1:0]      tmo, tmo_d;
  logic                  ready_d;
  logic                  pulse_d;
  logic                  strobe;
  logic                  start;
  logic                  ack_wait;
  logic                  abort;
  logic                  cnt_last;

  assign strobe   = bus_strobe_active(IOR_N, IOW_N, MEMR_N, MEMW_N);
  assign start    = strobe & device_select;
  assign ack_wait = use_ack & ~device_ack;
  assign cnt_last = (cnt <= WAIT_WIDTH'(1));
  // Strobe loss while stalling the CPU must release ready without waiting for a CPU edge.
  assign abort    = ~strobe & ((state == WAIT) | (state == ACK));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else if (cpu_clock_negedge) begin
      case (state)
        IDLE: begin
          if (start) begin
            if (wait_count != '0) next_state = WAIT;
            else if (ack_wait)    next_state = ACK;
            else                  next_state = HOLD;
          end
        end
        WAIT: begin
          if (cnt_last) next_state = ack_wait ? ACK : HOLD;
        end
        ACK: begin
          if (device_ack || (tmo == TMO_LAST)) next_state = HOLD;
        end
        HOLD: begin
          if (!strobe) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt;
    tmo_d   = tmo;
    ready_d = EXT_READY;
    pulse_d = 1'b0;
    if (abort) begin
      ready_d = 1'b1;
    end else if (cpu_clock_negedge) begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt_d   = wait_count;
            tmo_d   = '0;
            ready_d = !((wait_count != '0) || ack_wait);
          end
        end
        WAIT: begin
          if (cnt != '0) cnt_d = cnt - WAIT_WIDTH'(1);
          if (cnt_last) ready_d = !ack_wait;
        end
        ACK: begin
          if (tmo != TMO_MAX) tmo_d = tmo + TMO_W'(1);
          if (device_ack) begin
            ready_d = 1'b1;
          end else if (tmo == TMO_LAST) begin
            ready_d = 1'b1;
            pulse_d = 1'b1;
          end
        end
        HOLD: begin
          ready_d = 1'b1;
        end
        default: ready_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      tmo           <= '0;
      EXT_READY     <= 1'b1;
      timeout_pulse <= 1'b0;
    end else begin
      cnt           <= cnt_d;
      tmo           <= tmo_d;
      EXT_READY     <= ready_d;
      timeout_pulse <= pulse_d;
    end
  end

  assign busy = (state != IDLE);

  logic unused_ok;
  assign unused_ok = cpu_clock_posedge;

endmodule
